uart_rx_fifo: RTL and testbench

//  Next-generation UART packet receiver: parametrised packet width, configurable clocks-per-bit

---
 rtl/uart_rx_fifo.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART packet receiver with mid-bit sampling, glitch/framing/parity checks
// and a first-word-fall-through FIFO of received words with registered head outputs.
// Ports: clk, reset_n (async, active low), rx_in (serial, idle high), rd_en (pop head),
//   clr_errors (clear sticky flags), rx_data/parity_error (head word and its parity flag),
//   rx_empty, rx_full, fifo_count, framing_error, overflow (sticky status).
module uart_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int CLKS_PER_BIT = 1,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  input  logic             rd_en,
  input  logic             clr_errors,
  output logic [WIDTH-1:0] rx_data,
  output logic             parity_error,
  output logic             rx_empty,
  output logic             rx_full,
  output logic [CW-1:0]    fifo_count,
  output logic             framing_error,
  output logic             overflow
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int NW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [NW-1:0] CNT_HALF = NW'(HALF);
  localparam logic [NW-1:0] CNT_LAST = NW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  logic rx_d1, rx_d2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_in;
      rx_d2 <= rx_d1;
    end
  end

  state_t state, state_n;
  logic [NW-1:0] cnt, cnt_n;
  logic [BW-1:0] bitn, bitn_n;
  logic [WIDTH-1:0] shift;
  logic shift_en;
  logic frame_ok;
  logic frame_bad;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bitn_n = bitn;
    shift_en = 1'b0;
    frame_ok = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_d2) begin
          cnt_n = '0;
          bitn_n = '0;
          // At one clock per bit the detection cycle already is the
          // start-bit sample; the next cycle carries data bit 0.
          state_n = (CLKS_PER_BIT == 1) ? DATA : START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          bitn_n = '0;
          state_n = rx_d2 ? IDLE : DATA;
        end else begin
          cnt_n = cnt + NW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          shift_en = 1'b1;
          if (bitn == BIT_LAST) state_n = STOP;
          else bitn_n = bitn + BW'(1);
        end else begin
          cnt_n = cnt + NW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_d2) begin
            frame_ok = 1'b1;
            state_n = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + NW'(1);
        end
      end
      BRK: begin
        if (rx_d2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bitn <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bitn <= bitn_n;
      if (shift_en) shift[bitn] <= rx_d2;
    end
  end

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_par;
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] count, count_n;
  logic pop, push, drop, word_par;

  assign word_par = ~^shift;
  assign pop = rd_en && (count != '0);
  // A full FIFO still accepts the word when the head leaves this cycle.
  assign push = frame_ok && ((count != FULL_CNT) || pop);
  assign drop = frame_ok && !push;
  assign rptr_n = rptr + AW'(pop);
  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= shift;
      mem_par[wptr] <= word_par;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rx_data <= '0;
      parity_error <= 1'b0;
      framing_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      rptr <= rptr_n;
      count <= count_n;
      // Head register: bypass the incoming word when it becomes the head.
      if (count_n != '0) begin
        if (push && (rptr_n == wptr)) begin
          rx_data <= shift;
          parity_error <= word_par;
        end else begin
          rx_data <= mem_data[rptr_n];
          parity_error <= mem_par[rptr_n];
        end
      end
      framing_error <= frame_bad | (framing_error & ~clr_errors);
      overflow <= drop | (overflow & ~clr_errors);
    end
  end

  assign rx_empty = (count == '0);
  assign rx_full = (count == FULL_CNT);
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed stimulus for uart_rx_fifo
// against a queue-based reference model of the received-word stream.
module tb_uart_rx_fifo;

  localparam int W = 64;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx1 = 1'b1;
  logic rx8 = 1'b1;
  logic rd1 = 1'b0;
  logic rd8 = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] data1, data8;
  logic par1, par8, emp1, emp8, full1, full8;
  logic fe1, fe8, ov1, ov8;
  logic [2:0] cnt1, cnt8;

  int checks = 0;
  int failures = 0;
  logic [W:0] q1[$];
  logic ovf_m = 1'b0;
  logic fe_m = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.WIDTH(W), .CLKS_PER_BIT(1), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .rx_in(rx1), .rd_en(rd1),
    .clr_errors(clr), .rx_data(data1), .parity_error(par1),
    .rx_empty(emp1), .rx_full(full1), .fifo_count(cnt1),
    .framing_error(fe1), .overflow(ov1)
  );

  uart_rx_fifo #(.WIDTH(W), .CLKS_PER_BIT(8), .DEPTH(D)) dut8 (
    .clk(clk), .reset_n(reset_n), .rx_in(rx8), .rd_en(rd8),
    .clr_errors(clr), .rx_data(data8), .parity_error(par8),
    .rx_empty(emp8), .rx_full(full8), .fifo_count(cnt8),
    .framing_error(fe8), .overflow(ov8)
  );

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic par_of(input logic [W-1:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_frame(input logic [W-1:0] w, input logic stop_bit);
    if (!stop_bit) fe_m = 1'b1;
    else if (q1.size() < D) q1.push_back({par_of(w), w});
    else ovf_m = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cnt"}, W'(cnt1), W'(q1.size()));
    check({tag, "_empty"}, W'(emp1), W'(q1.size() == 0));
    check({tag, "_full"}, W'(full1), W'(q1.size() == D));
    check({tag, "_ovf"}, W'(ov1), W'(ovf_m));
    check({tag, "_fe"}, W'(fe1), W'(fe_m));
    if (q1.size() > 0) begin
      check({tag, "_data"}, data1, q1[0][W-1:0]);
      check({tag, "_par"}, W'(par1), W'(q1[0][W]));
    end
  endtask

  task automatic pop1(input string tag);
    check({tag, "_cnt"}, W'(cnt1), W'(q1.size()));
    if (q1.size() > 0) begin
      check({tag, "_data"}, data1, q1[0][W-1:0]);
      check({tag, "_par"}, W'(par1), W'(q1[0][W]));
      void'(q1.pop_front());
    end
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
  endtask

  task automatic rand_rd(input int mode);
    int r;
    check("t6_cnt", W'(cnt1), W'(q1.size()));
    r = $urandom_range(0, 59);
    rd1 = (mode == 2) ? (r < 15) : (mode == 1) ? (r == 0) : 1'b0;
    if (rd1 && q1.size() > 0) begin
      check("t6_data", data1, q1[0][W-1:0]);
      check("t6_par", W'(par1), W'(q1[0][W]));
      void'(q1.pop_front());
    end
  endtask

  // Drives the first nbits of a frame (start, WIDTH data LSB first, stop).
  task automatic send(input bit sel, input logic [W-1:0] w,
                      input logic stop_bit, input int nbits, input int mode);
    int cpb;
    logic [W+1:0] fr;
    cpb = sel ? 8 : 1;
    fr = {stop_bit, w, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (sel) rx8 = fr[i];
      else rx1 = fr[i];
      if (mode != 0 && !sel) begin
        if (i > 0 && i < W - 4) rand_rd(mode);
        else rd1 = 1'b0;
      end
      repeat (cpb) @(negedge clk);
    end
    rd1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] w;
    logic sb;
    int mode;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_state("reset");

    w = 64'h8000_0000_0000_0000;
    send(0, w, 1'b1, W + 2, 0);
    model_frame(w, 1'b1);
    idle(3);
    check_state("t2_first");
    check("t2_par0", W'(par1), '0);
    w = 64'h3;
    send(0, w, 1'b1, W + 2, 0);
    model_frame(w, 1'b1);
    idle(3);
    check_state("t2_second");
    pop1("t2_pop");
    idle(1);
    check_state("t2_head2");
    check("t2_par1", W'(par1), W'(1'b1));

    w = {$urandom, $urandom};
    send(0, w, 1'b1, 30, 0);
    reset_n = 1'b0;
    rx1 = 1'b1;
    @(negedge clk);
    q1.delete();
    check("rst_data", data1, '0);
    check("rst_par", W'(par1), '0);
    check("rst_empty", W'(emp1), W'(1'b1));
    check("rst_full", W'(full1), '0);
    check("rst_cnt", W'(cnt1), '0);
    check("rst_fe", W'(fe1), '0);
    check("rst_ovf", W'(ov1), '0);
    reset_n = 1'b1;
    idle(2);
    w = {$urandom, $urandom};
    send(0, w, 1'b1, W + 2, 0);
    model_frame(w, 1'b1);
    idle(3);
    check_state("t1_clean");

    rx8 = 1'b0;
    idle(2);
    rx8 = 1'b1;
    idle(40);
    check("t3_glitch_cnt", W'(cnt8), '0);
    check("t3_glitch_empty", W'(emp8), W'(1'b1));
    w = 64'hA5A5_A5A5_A5A5_A5A5;
    send(1, w, 1'b1, W + 2, 0);
    idle(4);
    check("t3_data", data8, w);
    check("t3_par", W'(par8), W'(par_of(w)));
    check("t3_cnt", W'(cnt8), W'(1));
    check("t3_full", W'(full8), '0);
    check("t3_fe", W'(fe8), '0);
    check("t3_ovf", W'(ov8), '0);

    w = {$urandom, $urandom};
    send(0, w, 1'b0, W + 2, 0);
    model_frame(w, 1'b0);
    idle(20);
    check_state("t4_low");
    rx1 = 1'b1;
    idle(5);
    check_state("t4_high");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    fe_m = 1'b0;
    check_state("t4_clr");

    while (q1.size() > 0) pop1("t5_pre");
    for (int k = 0; k < 5; k++) begin
      w = {$urandom, $urandom};
      send(0, w, 1'b1, W + 2, 0);
      model_frame(w, 1'b1);
    end
    idle(3);
    check_state("t5_full");
    w = {$urandom, $urandom};
    send(0, w, 1'b1, W + 2, 0);
    @(negedge clk);
    check("t5_head", data1, q1[0][W-1:0]);
    void'(q1.pop_front());
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    model_frame(w, 1'b1);
    idle(3);
    check_state("t5_swap");
    while (q1.size() > 0) pop1("t5_drain");
    idle(1);
    check_state("t5_empty");

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ovf_m = 1'b0;
    fe_m = 1'b0;
    for (int f = 0; f < 40; f++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) w = w & 64'h0000_0000_0000_00FF;
      sb = ($urandom_range(0, 9) != 0);
      mode = $urandom_range(0, 2);
      send(0, w, sb, W + 2, mode);
      rx1 = 1'b1;
      idle(3);
      model_frame(w, sb);
      check_state("t6_frame");
    end
    while (q1.size() > 0) pop1("t6_drain");
    idle(1);
    check_state("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
